// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core: FSM state encodings,
// the parity function and the compile-time configuration check.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    localparam int MAX_DATA_BITS = 9;

    // Parity bit to send for a zero-extended payload: even parity is the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic bit cfg_legal(input int data_bits, input int stop_bits, input int oversample);
        return (data_bits >= 5) && (data_bits <= MAX_DATA_BITS) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               (oversample >= 4) && ((oversample % 2) == 0);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-cycle tick every baud_div+1 clocks.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // >= rather than == so a divisor lowered while idle cannot strand the counter above it.
    always_comb begin
        tick  = (cnt_q >= baud_div);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART with compile-time frame format and a runtime baud divisor.
// TX and RX FSMs share one oversampling tick but are otherwise independent.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int               OS_W      = $clog2(OVERSAMPLE);
    localparam int               BIT_W     = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);
    localparam bit               HAS_PAR   = (PARITY_EN != 0);

    if (!cfg_legal(DATA_BITS, STOP_BITS, OVERSAMPLE)) begin : g_bad_cfg
        $fatal(1, "uart_core_param: illegal DATA_BITS/STOP_BITS/OVERSAMPLE");
    end

    logic tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .tick     (tick)
    );

    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [OS_W-1:0]      tx_os_q, tx_os_d;
    logic                 txd_q, txd_d;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_os_q == OS_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_bit_d   = tx_bit_q;
        tx_os_d    = tx_os_q;
        txd_d      = txd_q;
        if (tx_state_q != TX_IDLE && tick) begin
            tx_os_d = tx_bit_end ? '0 : tx_os_q + 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = parity_bit(MAX_DATA_BITS'(tx_data), ODD);
                    tx_os_d    = '0;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
                        if (HAS_PAR) begin
                            tx_state_d = TX_PARITY;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 1'b1;
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                    txd_d      = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_bit_q   <= '0;
            tx_os_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_bit_q   <= tx_bit_d;
            tx_os_q    <= tx_os_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_ready = (tx_state_q == TX_IDLE);
    assign txd      = txd_q;

    logic                 sync1_q, sync2_q, rx_prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [OS_W-1:0]      rx_os_q, rx_os_d;
    logic                 rx_bit_end, frame_done, frame_ferr;

    // Synchroniser resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_bit_end = tick && (rx_os_q == OS_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_bit_d   = rx_bit_q;
        rx_os_d    = rx_os_q;
        frame_done = 1'b0;
        frame_ferr = 1'b0;
        if (tick && (rx_state_q == RX_DATA || rx_state_q == RX_PARITY || rx_state_q == RX_STOP)) begin
            rx_os_d = rx_bit_end ? '0 : rx_os_q + 1'b1;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    rx_os_d    = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_os_q == OS_MID) begin
                        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                        rx_os_d    = '0;
                        rx_bit_d   = '0;
                    end else begin
                        rx_os_d = rx_os_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_par_d   = sync2_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    frame_done = 1'b1;
                    frame_ferr = !sync2_q;
                    rx_state_d = sync2_q ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                if (sync2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ovr_q, rx_ovr_d;

    // A completed frame is dropped only if the held word is still unaccepted this cycle.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        rx_valid_d = rx_valid_q && !rx_ready;
        rx_ovr_d   = 1'b0;
        if (frame_done) begin
            if (rx_valid_q && !rx_ready) begin
                rx_ovr_d = 1'b1;
            end else begin
                rx_data_d  = rx_shift_q;
                rx_ferr_d  = frame_ferr;
                rx_perr_d  = HAS_PAR && (rx_par_q != parity_bit(MAX_DATA_BITS'(rx_shift_q), ODD));
                rx_valid_d = 1'b1;
            end
        end
    end

    // NOTE: the receive holding register is reset too, since rx_data must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_bit_q   <= '0;
            rx_os_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_bit_q   <= rx_bit_d;
            rx_os_q    <= rx_os_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench: an 8N1 core (dut) and an 8E1 core (dut_p), each with optional
// txd->rxd loopback or a bench-driven rxd line.
module tb_uart_core_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd0;
    logic [15:0] baud_div_p = 16'd0;
    logic [7:0]  tx_data = 8'h00, tx_data_p = 8'h00;
    logic        tx_valid = 1'b0, tx_valid_p = 1'b0;
    logic        rx_ready = 1'b0, rx_ready_p = 1'b0;
    logic        rxd_drv = 1'b1, rxd_drv_p = 1'b1;
    logic        loop_en = 1'b0, loop_en_p = 1'b0;

    wire         tx_ready, txd, rx_valid, rx_frame_err, rx_parity_err, rx_overrun;
    wire  [7:0]  rx_data;
    wire         tx_ready_p, txd_p, rx_valid_p, rx_frame_err_p, rx_parity_err_p, rx_overrun_p;
    wire  [7:0]  rx_data_p;
    wire         rxd   = loop_en   ? txd   : rxd_drv;
    wire         rxd_p = loop_en_p ? txd_p : rxd_drv_p;

    int vectors     = 0;
    int miscompares = 0;
    int ovr_cnt     = 0;

    uart_core_param #(
        .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)
    ) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
        .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
    );

    uart_core_param #(
        .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)
    ) dut_p (
        .clk(clk), .rst(rst), .baud_div(baud_div_p),
        .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p), .txd(txd_p),
        .rxd(rxd_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
        .rx_frame_err(rx_frame_err_p), .rx_parity_err(rx_parity_err_p), .rx_overrun(rx_overrun_p)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_overrun === 1'b1) ovr_cnt++;
    end

    // Presents a word and returns on the negedge right after the accepting edge.
    task automatic send_word(input bit sel, input logic [7:0] w);
        int budget = 2000;
        @(negedge clk);
        if (sel) begin tx_data_p = w; tx_valid_p = 1'b1; end
        else     begin tx_data   = w; tx_valid   = 1'b1; end
        while ((sel ? tx_ready_p : tx_ready) !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL send_accept: tx_ready=0 after 2000 cycles, required 1");
        end
        @(posedge clk);
        @(negedge clk);
        if (sel) tx_valid_p = 1'b0; else tx_valid = 1'b0;
    endtask

    // Samples txd at mid-bit; exp bit k is the k-th bit on the line (bit 0 = start).
    task automatic sample_tx_frame(input bit sel, input logic [15:0] exp, input int nbits,
                                   input int first, input int step, input string name);
        for (int k = 0; k < nbits; k++) begin
            repeat (k == 0 ? first : step) @(negedge clk);
            vectors++;
            if ((sel ? txd_p : txd) !== exp[k]) begin
                miscompares++;
                $display("FAIL %s bit%0d: txd=%b, required %b", name, k, sel ? txd_p : txd, exp[k]);
            end
        end
    endtask

    task automatic wait_rx(input bit sel, input int budget, input string name);
        int n = 0;
        while ((sel ? rx_valid_p : rx_valid) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s: rx_valid=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic ack_rx(input bit sel, input string name);
        @(negedge clk);
        if (sel) rx_ready_p = 1'b1; else rx_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ((sel ? rx_valid_p : rx_valid) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ack: rx_valid=%b, required 0", name, sel ? rx_valid_p : rx_valid);
        end
        if (sel) rx_ready_p = 1'b0; else rx_ready = 1'b0;
    endtask

    task automatic drive_line(input bit sel, input logic v, input int cycles);
        @(negedge clk);
        if (sel) rxd_drv_p = v; else rxd_drv = v;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic drive_frame(input bit sel, input logic [7:0] d, input bit par_en,
                               input logic par, input logic stop);
        drive_line(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_line(sel, d[i], 16);
        if (par_en) drive_line(sel, par, 16);
        drive_line(sel, stop, 16);
    endtask

    task automatic test_reset();
        logic [7:0] obs [8];
        logic [7:0] req [8];
        repeat (2) @(negedge clk);
        obs = '{8'(txd), 8'(tx_ready), 8'(rx_valid), rx_data,
                8'(rx_frame_err), 8'(rx_parity_err), 8'(rx_overrun), 8'(txd_p)};
        req = '{8'd1, 8'd1, 8'd0, 8'h00, 8'd0, 8'd0, 8'd0, 8'd1};
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs[i] !== req[i]) begin
                miscompares++;
                $display("FAIL reset_out%0d: got %h, required %h", i, obs[i], req[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_tx_basic();
        send_word(0, 8'hA5);
        vectors += 2;
        if (txd !== 1'b0) begin miscompares++; $display("FAIL tx_start_edge: txd=%b, required 0", txd); end
        if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL tx_busy: tx_ready=%b, required 0", tx_ready); end
        sample_tx_frame(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 8, 16, "tx_a5");
        repeat (7) @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL tx_ready_159: got %b, required 0", tx_ready); end
        @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL tx_ready_160: got %b, required 1", tx_ready); end
    endtask

    task automatic test_baud_div();
        @(negedge clk);
        baud_div = 16'd2;
        send_word(0, 8'h96);
        sample_tx_frame(0, {6'd0, 1'b1, 8'h96, 1'b0}, 10, 23, 48, "tx_div2");
        repeat (15) @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL div2_busy: tx_ready=%b, required 0", tx_ready); end
        repeat (15) @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL div2_done: tx_ready=%b, required 1", tx_ready); end
        baud_div = 16'd0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got_d [4];
        logic       got_fe [4];
        logic       got_pe [4];
        int         n = 0;
        int         o0;
        loop_en  = 1'b1;
        rx_ready = 1'b1;
        o0       = ovr_cnt;
        fork
            begin
                send_word(0, 8'h3C);
                send_word(0, 8'hC3);
            end
            begin
                for (int c = 0; c < 600; c++) begin
                    @(negedge clk);
                    if (rx_valid === 1'b1) begin
                        if (n < 4) begin
                            got_d[n] = rx_data; got_fe[n] = rx_frame_err; got_pe[n] = rx_parity_err;
                        end
                        n++;
                    end
                end
            end
        join
        vectors += 4;
        if (n != 2) begin miscompares++; $display("FAIL b2b_count: %0d rx_valid cycles, required 2", n); end
        if (got_d[0] !== 8'h3C) begin miscompares++; $display("FAIL b2b_word0: got %h, required 3c", got_d[0]); end
        if (got_d[1] !== 8'hC3) begin miscompares++; $display("FAIL b2b_word1: got %h, required c3", got_d[1]); end
        if (ovr_cnt != o0) begin miscompares++; $display("FAIL b2b_overrun: %0d pulses, required 0", ovr_cnt - o0); end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({got_fe[i], got_pe[i]} !== 2'b00) begin
                miscompares++;
                $display("FAIL b2b_flags%0d: fe,pe=%b%b, required 00", i, got_fe[i], got_pe[i]);
            end
        end
        loop_en  = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic test_parity();
        loop_en_p = 1'b1;
        send_word(1, 8'h07);
        sample_tx_frame(1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 8, 16, "tx_par07");
        wait_rx(1, 40, "par_loop_rx");
        vectors++;
        if ({rx_data_p, rx_parity_err_p, rx_frame_err_p} !== {8'h07, 2'b00}) begin
            miscompares++;
            $display("FAIL par_loop: data=%h pe=%b fe=%b, required 07 0 0", rx_data_p, rx_parity_err_p, rx_frame_err_p);
        end
        ack_rx(1, "par_loop");
        loop_en_p = 1'b0;
        drive_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_rx(1, 20, "par_bad_rx");
        vectors++;
        if ({rx_data_p, rx_parity_err_p, rx_frame_err_p} !== {8'h07, 2'b10}) begin
            miscompares++;
            $display("FAIL par_bad: data=%h pe=%b fe=%b, required 07 1 0", rx_data_p, rx_parity_err_p, rx_frame_err_p);
        end
        ack_rx(1, "par_bad");
    endtask

    task automatic test_false_start_and_framing();
        drive_line(0, 1'b0, 4);
        drive_line(0, 1'b1, 40);
        vectors++;
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL glitch: rx_valid=%b, required 0", rx_valid); end
        drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_rx(0, 20, "after_glitch_rx");
        vectors++;
        if ({rx_data, rx_frame_err} !== {8'hA5, 1'b0}) begin
            miscompares++;
            $display("FAIL after_glitch: data=%h fe=%b, required a5 0", rx_data, rx_frame_err);
        end
        ack_rx(0, "after_glitch");
        drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_rx(0, 20, "frame_err_rx");
        vectors++;
        if ({rx_data, rx_frame_err, rx_parity_err} !== {8'h55, 2'b10}) begin
            miscompares++;
            $display("FAIL frame_err: data=%h fe=%b pe=%b, required 55 1 0", rx_data, rx_frame_err, rx_parity_err);
        end
        ack_rx(0, "frame_err");
        drive_line(0, 1'b0, 48);
        vectors++;
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL line_low: rx_valid=%b, required 0", rx_valid); end
        drive_line(0, 1'b1, 16);
        drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_rx(0, 20, "rearm_rx");
        vectors++;
        if ({rx_data, rx_frame_err} !== {8'h3C, 1'b0}) begin
            miscompares++;
            $display("FAIL rearm: data=%h fe=%b, required 3c 0", rx_data, rx_frame_err);
        end
        ack_rx(0, "rearm");
    endtask

    task automatic test_overrun();
        int o0 = ovr_cnt;
        drive_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_rx(0, 20, "ovr_first_rx");
        vectors++;
        if (rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_first: data=%h, required 11", rx_data); end
        drive_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        vectors += 3;
        if (ovr_cnt - o0 != 1) begin miscompares++; $display("FAIL ovr_pulses: %0d, required 1", ovr_cnt - o0); end
        if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid: rx_valid=%b, required 1", rx_valid); end
        if ({rx_data, rx_frame_err} !== {8'h11, 1'b0}) begin
            miscompares++;
            $display("FAIL ovr_hold: data=%h fe=%b, required 11 0", rx_data, rx_frame_err);
        end
        @(negedge clk);
        rx_ready = 1'b1;
        vectors++;
        if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_pre_ack: rx_valid=%b, required 1", rx_valid); end
        @(negedge clk);
        vectors++;
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_ack: rx_valid=%b, required 0", rx_valid); end
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_tx();
        send_word(0, 8'h00);
        repeat (72) @(negedge clk);
        vectors++;
        if (txd !== 1'b0) begin miscompares++; $display("FAIL mid_bit3: txd=%b, required 0", txd); end
        rst = 1'b1;
        #1;
        vectors += 2;
        if (txd !== 1'b1) begin miscompares++; $display("FAIL rst_txd: txd=%b, required 1", txd); end
        if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: tx_ready=%b, required 1", tx_ready); end
        @(negedge clk);
        rst = 1'b0;
        send_word(0, 8'h5A);
        sample_tx_frame(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 8, 16, "tx_5a");
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_baud_div();
        test_back_to_back();
        test_parity();
        test_false_start_and_framing();
        test_overrun();
        test_reset_mid_tx();
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
